// File: rtl/uart_alu_ctrl.sv
// -----------------------------------------------------------------------------
// uart_alu_ctrl
//
// Packet engine that sits between the UART receive stream and the UART
// transmit stream. It parses byte packets of the form
//   [opcode, rsvd, len_lo, len_hi, payload...]
// where len is the total packet length including the 4-byte header.
//
//   OP_ECHO : payload is streamed straight back out, byte for byte.
//   OP_ADD  : payload is a list of 32-bit little-endian operands; the wrapping
//             sum is returned as 4 little-endian bytes.
//   OP_MUL  : as OP_ADD, but the low 32 bits of the product are returned.
//
// Unknown opcodes and arithmetic packets with an unusable length are consumed
// and discarded. drop_o pulses together with the last byte of the packet.
//
// Ports
//   clk_i          in   1  clock, all logic on the rising edge
//   reset_i        in   1  synchronous, active-high reset
//   s_axis_tdata   in   8  byte from UART RX
//   s_axis_tvalid  in   1  RX byte valid
//   s_axis_tready  out  1  this block accepts the RX byte
//   m_axis_tdata   out  8  byte to UART TX
//   m_axis_tvalid  out  1  TX byte valid
//   m_axis_tready  in   1  UART TX accepts the byte
//   busy_o         out  1  high whenever a packet is in progress
//   drop_o         out  1  one-cycle pulse when a packet is discarded
// -----------------------------------------------------------------------------
module uart_alu_ctrl #(
  parameter logic [7:0] OP_ECHO = 8'hEC,
  parameter logic [7:0] OP_ADD  = 8'hA0,
  parameter logic [7:0] OP_MUL  = 8'hA1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       busy_o,
  output logic       drop_o
);

  typedef enum logic [2:0] {
    ST_HDR,
    ST_ECHO,
    ST_OPND,
    ST_RES,
    ST_DROP
  } state_t;

  state_t      r_state;
  logic [1:0]  r_hdr_cnt;   // header byte index 0..3
  logic [7:0]  r_opcode;
  logic [7:0]  r_len_lo;
  logic [15:0] r_rem;       // payload bytes still to be transferred
  logic [1:0]  r_wb_cnt;    // byte index inside the current operand word
  logic [23:0] r_word;      // low three bytes of the operand being assembled
  logic        r_first;     // next complete word is the first operand
  logic [31:0] r_acc;
  logic [1:0]  r_res_idx;   // result byte being presented

  logic        w_s_fire;
  logic        w_m_fire;
  logic [15:0] w_len;
  logic        w_is_arith;
  logic        w_arith_ok;
  logic [31:0] w_word;
  logic [31:0] w_acc_next;
  logic [7:0]  w_res_byte;
  state_t      w_hdr_next;
  logic        w_hdr_drop;

  assign w_s_fire   = s_axis_tvalid & s_axis_tready;
  assign w_m_fire   = m_axis_tvalid & m_axis_tready;

  // Length is only meaningful while the 4th header byte (len_hi) is on the bus.
  assign w_len      = {s_axis_tdata, r_len_lo};
  assign w_is_arith = (r_opcode == OP_ADD) || (r_opcode == OP_MUL);
  assign w_arith_ok = (w_len >= 16'd8) && (w_len[1:0] == 2'b00);

  // Complete operand word when its 4th byte is on the bus.
  assign w_word     = {s_axis_tdata, r_word};
  assign w_acc_next = r_first                ? w_word :
                      (r_opcode == OP_ADD)   ? r_acc + w_word :
                                               r_acc * w_word;

  assign w_res_byte = r_acc[8*r_res_idx +: 8];
  assign busy_o     = (r_state != ST_HDR);

  // Where the packet goes once the header is complete. A header that claims
  // fewer than 4 bytes cannot carry a payload and is treated as malformed.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the case/if tree can infer a latch.
    w_hdr_next = ST_HDR;
    w_hdr_drop = 1'b0;
    if (r_opcode == OP_ECHO && w_len >= 16'd4) begin
      w_hdr_next = (w_len == 16'd4) ? ST_HDR : ST_ECHO;
    end else if (w_is_arith && w_arith_ok) begin
      w_hdr_next = ST_OPND;
    end else if (w_len <= 16'd4) begin
      w_hdr_drop = 1'b1;
    end else begin
      w_hdr_next = ST_DROP;
    end
  end

  // Stream handshakes. ECHO is a pure pass-through with no added latency;
  // RES presents the registered accumulator one byte at a time.
  always_comb begin
    s_axis_tready = 1'b1;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = w_res_byte;
    drop_o        = 1'b0;
    unique case (r_state)
      ST_HDR:  drop_o = s_axis_tvalid && (r_hdr_cnt == 2'd3) && w_hdr_drop;
      ST_ECHO: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
      end
      ST_OPND: ;
      ST_RES: begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b1;
      end
      ST_DROP: drop_o = s_axis_tvalid && (r_rem == 16'd1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values and the block order does not matter.
    if (reset_i) begin
      r_state   <= ST_HDR;
      r_hdr_cnt <= 2'd0;
      r_opcode  <= 8'h00;
      r_len_lo  <= 8'h00;
      r_rem     <= 16'd0;
      r_wb_cnt  <= 2'd0;
      r_word    <= 24'd0;
      r_first   <= 1'b1;
      r_acc     <= 32'd0;
      r_res_idx <= 2'd0;
    end else begin
      unique case (r_state)
        ST_HDR: begin
          if (w_s_fire) begin
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
            case (r_hdr_cnt)
              2'd0:    r_opcode <= s_axis_tdata;
              2'd2:    r_len_lo <= s_axis_tdata;
              2'd3: begin
                r_state   <= w_hdr_next;
                r_rem     <= w_len - 16'd4;
                r_wb_cnt  <= 2'd0;
                r_first   <= 1'b1;
                r_res_idx <= 2'd0;
              end
              default: ;
            endcase
          end
        end

        ST_ECHO: begin
          if (w_s_fire) begin
            r_rem <= r_rem - 16'd1;
            if (r_rem == 16'd1) r_state <= ST_HDR;
          end
        end

        ST_OPND: begin
          if (w_s_fire) begin
            r_rem    <= r_rem - 16'd1;
            r_wb_cnt <= r_wb_cnt + 2'd1;
            case (r_wb_cnt)
              2'd0: r_word[7:0]   <= s_axis_tdata;
              2'd1: r_word[15:8]  <= s_axis_tdata;
              2'd2: r_word[23:16] <= s_axis_tdata;
              default: begin
                r_acc   <= w_acc_next;
                r_first <= 1'b0;
              end
            endcase
            // Length was checked to be a multiple of 4, so the last payload
            // byte always completes a word.
            if (r_rem == 16'd1) r_state <= ST_RES;
          end
        end

        ST_RES: begin
          if (w_m_fire) begin
            r_res_idx <= r_res_idx + 2'd1;
            if (r_res_idx == 2'd3) r_state <= ST_HDR;
          end
        end

        ST_DROP: begin
          if (w_s_fire) begin
            r_rem <= r_rem - 16'd1;
            if (r_rem == 16'd1) r_state <= ST_HDR;
          end
        end

        default: r_state <= ST_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_ctrl
//
// Self-checking bench for uart_alu_ctrl. Packets come from a table of
// {bytes, expected TX bytes, expected drop pulses}. Expected TX bytes are
// queued when a packet is driven and popped by a monitor as the DUT
// transmits. Hand-written sequences cover reset mid-packet and in RES.
// -----------------------------------------------------------------------------
module tb_uart_alu_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       busy_o;
  logic       drop_o;

  uart_alu_ctrl dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy_o        (busy_o),
    .drop_o        (drop_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef enum int { K_NONE, K_ECHO, K_RES } kind_t;

  typedef struct {
    string      name;
    int         n;
    logic [7:0] pkt [20];
    int         nexp;
    logic [7:0] exp [20];
    int         ndrop;
    bit         idle_after; // packet ends in HDR right after its last byte
  } vec_t;

  vec_t       vecs [16];
  int         nvec;
  logic [7:0] exp_q [$];

  int         errors;
  int         checks;
  int         drop_cnt;
  logic [7:0] last_drop_byte;
  int         m_mode;   // 0 ready, 1 toggle, 2 20-low then toggle, 3 held low
  bit         prev_stall;
  logic [7:0] prev_data;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // bytes holds the packet MSB-first: the first byte is bytes[8*n-1 -: 8].
  task automatic add_vec(input string name, input logic [159:0] bytes,
                         input int n, input kind_t kind, input logic [31:0] res,
                         input int ndrop, input bit idle_after);
    vecs[nvec].name       = name;
    vecs[nvec].n          = n;
    vecs[nvec].ndrop      = ndrop;
    vecs[nvec].idle_after = idle_after;
    vecs[nvec].nexp       = 0;
    for (int i = 0; i < n; i++) vecs[nvec].pkt[i] = bytes[8*(n-1-i) +: 8];
    if (kind == K_ECHO) begin
      vecs[nvec].nexp = n - 4;
      for (int i = 4; i < n; i++) vecs[nvec].exp[i-4] = vecs[nvec].pkt[i];
    end else if (kind == K_RES) begin
      vecs[nvec].nexp = 4;
      for (int k = 0; k < 4; k++) vecs[nvec].exp[k] = res[8*k +: 8];
    end
    nvec++;
  endtask

  // Hold the byte until the DUT takes it; inputs change 1 time unit after
  // the rising edge, ready is sampled on the falling edge.
  task automatic send_byte(input logic [7:0] b);
    int k;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk_i);
      if (s_axis_tready) begin
        @(posedge clk_i); #1;
        break;
      end
      @(posedge clk_i); #1;
    end
    if (k == 2000) check("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && !busy_o) break;
    end
    if (k == 1000) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_pkt(input vec_t v);
    drop_cnt = 0;
    for (int i = 0; i < v.nexp; i++) exp_q.push_back(v.exp[i]);
    for (int i = 0; i < v.n; i++) send_byte(v.pkt[i]);
    s_axis_tvalid = 1'b0;
    if (v.idle_after) check({v.name, "_busy_after_last"}, busy_o, 1'b0);
    wait_idle();
    @(posedge clk_i); #1;
    check({v.name, "_tx_drained"}, exp_q.size(), 0);
    check({v.name, "_drops"}, drop_cnt, v.ndrop);
    if (v.ndrop > 0)
      check({v.name, "_drop_byte"}, last_drop_byte, v.pkt[v.n-1]);
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_tready"}, s_axis_tready, 1'b1);
    check({tag, "_m_tvalid"}, m_axis_tvalid, 1'b0);
    check({tag, "_busy"},     busy_o,        1'b0);
    check({tag, "_drop"},     drop_o,        1'b0);
  endtask

  // m_axis_tready generator.
  initial begin
    int cyc;
    cyc = 0;
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      cyc++;
      case (m_mode)
        1:       m_axis_tready = cyc[0];
        2:       m_axis_tready = (cyc % 30 < 20) ? 1'b0 : cyc[0];
        3:       m_axis_tready = 1'b0;
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

  // TX monitor / scoreboard.
  initial begin
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("tx_hold_valid", m_axis_tvalid, 1'b1);
          check("tx_hold_data",  m_axis_tdata,  prev_data);
        end
        if (m_axis_tvalid && !s_axis_tvalid)
          check("res_s_tready_low", s_axis_tready, 1'b0);
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got %0h expected no byte at %0t",
                     m_axis_tdata, $time);
          end else begin
            check("tx_byte", m_axis_tdata, exp_q.pop_front());
          end
        end
        if (drop_o) begin
          drop_cnt++;
          last_drop_byte = s_axis_tdata;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    errors = 0;
    checks = 0;
    nvec   = 0;
    m_mode = 0;
    drop_cnt = 0;
    last_drop_byte = 8'h00;
    reset_i       = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;

    add_vec("echo3",     160'hEC_00_07_00_41_42_43, 7, K_ECHO, 32'h0, 0, 1);
    add_vec("add_5",     160'hA0_00_0C_00_02_00_00_00_03_00_00_00, 12, K_RES, 32'h5, 0, 0);
    add_vec("add_wrap",  160'hA0_00_0C_00_01_00_00_00_FF_FF_FF_FF, 12, K_RES, 32'h0, 0, 0);
    add_vec("mul_ovf",   160'hA1_00_0C_00_00_00_01_00_00_00_01_00, 12, K_RES, 32'h0, 0, 0);
    add_vec("mul_3op",   160'hA1_00_10_00_02_00_00_00_03_00_00_00_07_00_00_00, 16, K_RES, 32'h2A, 0, 0);
    add_vec("drop_op",   160'h55_00_06_00_AA_BB, 6, K_NONE, 32'h0, 1, 1);
    add_vec("add_1op",   160'hA0_00_08_00_09_00_00_00, 8, K_RES, 32'h9, 0, 0);
    add_vec("drop_len",  160'hA0_00_0A_00_11_22_33_44_55_66, 10, K_NONE, 32'h0, 1, 1);
    add_vec("echo_empty",160'hEC_00_04_00, 4, K_NONE, 32'h0, 0, 1);
    add_vec("drop_hdr",  160'h33_00_04_00, 4, K_NONE, 32'h0, 1, 1);
    add_vec("add_len4",  160'hA0_00_04_00, 4, K_NONE, 32'h0, 1, 1);
    add_vec("echo5",     160'hEC_00_09_00_00_FF_5A_A5_80, 9, K_ECHO, 32'h0, 0, 1);
    add_vec("add_rsvd",  160'hA0_7E_0C_00_11_11_11_11_22_22_22_22, 12, K_RES, 32'h33333333, 0, 0);
    add_vec("mul_mix",   160'hA1_00_0C_00_03_00_01_00_05_00_00_00, 12, K_RES, 32'h0005000F, 0, 0);

    repeat (3) @(posedge clk_i);
    #1;
    check_reset_vals("por");
    reset_i = 1'b0;
    @(posedge clk_i); #1;

    // Full table with TX always ready.
    for (int i = 0; i < nvec; i++) run_pkt(vecs[i]);

    // Backpressure: toggling ready, then a long stall followed by toggling.
    m_mode = 1;
    run_pkt(vecs[1]);
    run_pkt(vecs[0]);
    run_pkt(vecs[11]);
    m_mode = 2;
    run_pkt(vecs[1]);
    run_pkt(vecs[11]);
    m_mode = 0;

    // Reset after 6 bytes of an ADD packet: no result may appear.
    drop_cnt = 0;
    for (int i = 0; i < 6; i++) send_byte(vecs[1].pkt[i]);
    s_axis_tvalid = 1'b0;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    check_reset_vals("rst_opnd");
    reset_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    check("rst_opnd_no_drop", drop_cnt, 0);

    // Reset while the result is stalled in RES: result bytes are lost.
    m_mode = 3;
    for (int i = 0; i < vecs[1].n; i++) send_byte(vecs[1].pkt[i]);
    s_axis_tvalid = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (m_axis_tvalid) break;
    end
    check("res_stall_valid", m_axis_tvalid, 1'b1);
    check("res_stall_byte0", m_axis_tdata, 8'h05);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    check_reset_vals("rst_res");
    reset_i = 1'b0;
    m_mode  = 0;
    repeat (10) @(posedge clk_i);
    #1;

    // A fresh packet after the resets is parsed from its opcode.
    run_pkt(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
